// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 UART receiver that oversamples the line at CLKS_PER_BIT clocks per bit.
// Bits are sampled mid-bit; each good frame updates oDATA and pulses oDONE for one cycle.
module rs232_rx #(
    parameter int CLKS_PER_BIT = 6
) (
    input  logic       clk_s,
    input  logic       rstn_s,
    input  logic       iDATA,
    output logic [7:0] oDATA,
    output logic       oDONE
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF_LAST = W'(HALF_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t       state, state_n;
    logic         rx_m, rx_s;
    logic [W-1:0] cnt, cnt_n;
    logic [2:0]   idx, idx_n;
    logic [7:0]   shift, shift_n, data_n;
    logic         done_n;

    always_ff @(posedge clk_s) begin
        if (!rstn_s) begin
            rx_m  <= 1'b1;
            rx_s  <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            oDATA <= '0;
            oDONE <= 1'b0;
        end else begin
            rx_m  <= iDATA;
            rx_s  <= rx_m;
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            oDATA <= data_n;
            oDONE <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        data_n  = oDATA;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: if (cnt == HALF_LAST) begin
                // a line that has gone high again by mid start bit was a glitch
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_n        = '0;
                shift_n[idx] = rx_s;
                idx_n        = idx + 1'b1;
                if (idx == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == LAST) begin
                cnt_n   = '0;
                state_n = IDLE;
                if (rx_s) begin
                    data_n = shift;
                    done_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: randomized frame stimulus checked against a byte-level model of the receiver.
module tb_rs232_rx;
    localparam int CPB = 6;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk_s = 1'b0;
    logic       rstn_s = 1'b0;
    logic       iDATA = 1'b1;
    logic [7:0] oDATA;
    logic       oDONE;

    rs232_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_s(clk_s),
        .rstn_s(rstn_s),
        .iDATA(iDATA),
        .oDATA(oDATA),
        .oDONE(oDONE)
    );

    always #5 clk_s = ~clk_s;

    int         cyc = 0, vectors = 0, errors = 0, width_err = 0, stable_err = 0;
    logic [7:0] got_q[$], exp_q[$];
    int         done_t[$], start_q[$];
    logic       prev_done = 1'b0, prev_rstn = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk_s) cyc++;

    // oDONE must be single-cycle and oDATA may only move with oDONE or a reset
    always @(negedge clk_s) begin
        if (oDONE) begin
            got_q.push_back(oDATA);
            done_t.push_back(cyc);
            if (prev_done) width_err++;
        end
        if (prev_rstn && !oDONE && oDATA !== prev_data) stable_err++;
        prev_done = oDONE;
        prev_data = oDATA;
        prev_rstn = rstn_s;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_s);
            #2;
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
        done_t.delete();
        start_q.delete();
    endtask

    // a frame is expected to be delivered exactly when its stop bit is high
    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
        iDATA = 1'b0;
        if (stop) begin
            exp_q.push_back(b);
            start_q.push_back(cyc);
        end
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            iDATA = b[i];
            tick(CPB);
        end
        iDATA = stop;
        tick(CPB);
        iDATA = 1'b1;
        tick(gap);
    endtask

    task automatic test_reset();
        rstn_s = 1'b0;
        iDATA  = 1'b1;
        tick(50);
        vectors++;
        if (oDATA !== 8'h00 || oDONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: oDATA=%h oDONE=%b, need 00/0", oDATA, oDONE);
        end
        rstn_s = 1'b1;
        tick(150);
        vectors++;
        if (got_q.size() != 0 || oDATA !== 8'h00) begin
            errors++;
            $display("FAIL idle: pulses=%0d oDATA=%h, need 0/00", got_q.size(), oDATA);
        end
    endtask

    task automatic test_single();
        clear_q();
        send_frame(8'h55, 1'b1, 20);
        vectors++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL single_count: pulses=%0d, need 1", got_q.size());
        end else begin
            vectors++;
            if (got_q[0] !== 8'h55) begin
                errors++;
                $display("FAIL single_data: got %h, need 55", got_q[0]);
            end
            vectors++;
            if (done_t[0] - start_q[0] != LAT) begin
                errors++;
                $display("FAIL single_latency: got %0d, need %0d", done_t[0] - start_q[0], LAT);
            end
        end
        vectors++;
        if (oDATA !== 8'h55 || width_err != 0) begin
            errors++;
            $display("FAIL single_hold: oDATA=%h width_err=%0d, need 55/0", oDATA, width_err);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] seq [4] = '{8'hA3, 8'h00, 8'hFF, 8'h81};
        clear_q();
        foreach (seq[i]) send_frame(seq[i], 1'b1, 50);
        vectors++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL seq_count: pulses=%0d, need 4", got_q.size());
        end
        foreach (got_q[i]) begin
            vectors++;
            if (i < 4 && got_q[i] !== seq[i]) begin
                errors++;
                $display("FAIL seq_data[%0d]: got %h, need %h", i, got_q[i], seq[i]);
            end
        end
        vectors++;
        if (stable_err != 0) begin
            errors++;
            $display("FAIL seq_stable: %0d unexpected oDATA changes, need 0", stable_err);
        end
    endtask

    task automatic test_false_start();
        clear_q();
        iDATA = 1'b0;
        tick(1);
        iDATA = 1'b1;
        tick(20);
        vectors++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_pulse: pulses=%0d, need 0", got_q.size());
        end
        send_frame(8'h3C, 1'b1, 20);
        vectors++;
        if (got_q.size() != 1 || oDATA !== 8'h3C) begin
            errors++;
            $display("FAIL glitch_recover: pulses=%0d oDATA=%h, need 1/3c", got_q.size(), oDATA);
        end
    endtask

    task automatic test_framing_error();
        clear_q();
        send_frame(8'h5A, 1'b0, 30);
        vectors++;
        if (got_q.size() != 0 || oDATA !== 8'h3C) begin
            errors++;
            $display("FAIL frame_err: pulses=%0d oDATA=%h, need 0/3c", got_q.size(), oDATA);
        end
        send_frame(8'hC3, 1'b1, 20);
        vectors++;
        if (got_q.size() != 1 || oDATA !== 8'hC3) begin
            errors++;
            $display("FAIL frame_recover: pulses=%0d oDATA=%h, need 1/c3", got_q.size(), oDATA);
        end
    endtask

    // upper nibble kept high so the line stays idle once reset has aborted the frame
    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = {4'hF, 4'($urandom)};
        clear_q();
        iDATA = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            iDATA = b[i];
            tick(CPB);
        end
        iDATA = b[4];
        tick(1);
        rstn_s = 1'b0;
        tick(3);
        vectors++;
        if (oDATA !== 8'h00 || oDONE !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: oDATA=%h oDONE=%b, need 00/0", oDATA, oDONE);
        end
        rstn_s = 1'b1;
        tick(CPB - 4);
        for (int i = 5; i < 8; i++) begin
            iDATA = b[i];
            tick(CPB);
        end
        iDATA = 1'b1;
        tick(CPB + 30);
        vectors++;
        if (got_q.size() != 0 || oDATA !== 8'h00) begin
            errors++;
            $display("FAIL midrst_pulse: pulses=%0d oDATA=%h, need 0/00", got_q.size(), oDATA);
        end
        send_frame(8'h7E, 1'b1, 20);
        vectors++;
        if (got_q.size() != 1 || oDATA !== 8'h7E) begin
            errors++;
            $display("FAIL midrst_recover: pulses=%0d oDATA=%h, need 1/7e", got_q.size(), oDATA);
        end
    endtask

    task automatic test_back_to_back();
        logic stop;
        int   gap;
        clear_q();
        for (int i = 0; i < 24; i++) begin
            stop = ($urandom_range(0, 5) != 0);
            gap  = (i % 3 == 0) ? 0 : $urandom_range(0, 12);
            if (!stop && gap < 5) gap = 5;
            if (i == 23) gap = 20;
            send_frame(8'($urandom), stop, gap);
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: pulses=%0d, need %0d", got_q.size(), exp_q.size());
        end
        foreach (got_q[i]) begin
            if (i < exp_q.size()) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h, need %h", i, got_q[i], exp_q[i]);
                end
                vectors++;
                if (done_t[i] - start_q[i] != LAT) begin
                    errors++;
                    $display("FAIL b2b_latency[%0d]: got %0d, need %0d", i, done_t[i] - start_q[i], LAT);
                end
            end
        end
        vectors++;
        if (width_err != 0 || stable_err != 0) begin
            errors++;
            $display("FAIL b2b_pulse_rules: width_err=%0d stable_err=%0d, need 0/0", width_err, stable_err);
        end
    endtask

    initial begin
        @(posedge clk_s);
        #2;
        test_reset();
        test_single();
        test_sequence();
        test_false_start();
        test_framing_error();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/rs232_rx.md
Name: rs232_rx

Overview:
- Asynchronous RS-232/UART serial receiver, 8N1 framing: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), no parity.
- Oversamples the serial line with the system clock, samples each bit at mid-bit and presents the received byte on a parallel output.
- Pulses a one-cycle done strobe per valid frame. Sits between the board RX pin and the byte-consuming logic.

Parameters:
- CLKS_PER_BIT, 6, system clocks per serial bit (baud divisor); legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (floor), clocks from the start-edge detect to the start-bit mid-point check; derived, not overridable.

Ports:
- clk_s  input  1  system clock; all logic on the rising edge.
- rstn_s  input  1  synchronous active-low reset.
- iDATA  input  1  asynchronous serial line; idles high.
- oDATA  output  8  last correctly received byte; registered.
- oDONE  output  1  one-cycle pulse: a valid frame completed and oDATA was updated.

Behaviour:
- One clock (clk_s). Reset is synchronous, active-low, on rstn_s.
- Reset (rstn_s=0 at a clk_s edge):
  - oDATA=8'h00, oDONE=0, FSM=IDLE, counters=0.
  - Synchronizer flops preset to 1 (idle line).
  - Reset asserted mid-frame aborts the frame: no oDONE, oDATA cleared.
- Input path: iDATA passes a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: wait for rx_s==0; then clear the clock counter and go to START.
  - START: count HALF_BIT-1 clocks.
    - rx_s still 0: clear the counter, clear the bit index, go to DATA.
    - rx_s is 1: false start (glitch); go to IDLE, no output change.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into shift register bit [index] (LSB first) and increment index.
    - After the 8th sample go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - rx_s==1: load oDATA with the shift register and assert oDONE on the next clock edge for exactly 1 cycle; go to IDLE.
    - rx_s==0: framing error; discard the byte, oDATA holds, no oDONE; go to IDLE.
  - From IDLE, a new frame starts only on a low rx_s level. Back-to-back frames with zero idle gap after the stop bit must be received.
- oDATA holds its value between frames. It changes only on the cycle oDONE rises.
- oDONE latency:
  - 2 sync clocks + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks after the iDATA start falling edge.
  - With defaults: ~60 clocks, i.e. inside the stop bit.
- iDATA activity during DATA/STOP states is sampled only at sample points; no restart is triggered.
- Counter widths sized for CLKS_PER_BIT; bit index 3 bits.

Test Plan:
- Reset/idle: hold rstn_s=0 50 clocks with iDATA=1, then release and keep idle 150 clocks -> oDATA=8'h00, oDONE never asserted.
- Single frame: send 8'h55 (6 clocks/bit, LSB first) -> exactly one oDONE pulse, 1 cycle wide, ~60 clocks after the start edge; oDATA=8'h55 at and after the pulse.
- Sequence: send 8'hA3, 8'h00, 8'hFF, 8'h81, each followed by 50 idle clocks -> four oDONE pulses with oDATA = A3, 00, FF, 81 in order; oDATA stable between pulses.
- False start: drive iDATA low for 1 clock, then high -> no oDONE; FSM back in IDLE; a following 8'h3C frame is received correctly.
- Framing error: send 8'h5A with stop bit = 0, then line high -> no oDONE, oDATA keeps its previous value; the next valid 8'hC3 frame yields oDONE and oDATA=8'hC3.
- Reset mid-frame: assert rstn_s=0 during data bit 4 of a frame -> oDATA=8'h00, oDONE=0, no pulse for that frame; the next full frame 8'h7E is received normally.
